// File: rtl/mult_seq_if.sv
// Request/response bundle for the sequential multiplier.
// The master issues start plus operands; the slave reports busy/done/product.
interface mult_seq_if #(
  parameter int WIDTH = 32
);
  logic               start;
  logic               is_signed;
  logic [WIDTH-1:0]   multiplicand;
  logic [WIDTH-1:0]   multiplier;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  modport master (
    output start, is_signed, multiplicand, multiplier,
    input  busy, done, product
  );

  modport slave (
    input  start, is_signed, multiplicand, multiplier,
    output busy, done, product
  );
endinterface

// File: rtl/mult_seq.sv
// Iterative shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, signed or unsigned.
// Signed operands are converted to magnitudes at accept; the shared adder
// accumulates magnitudes and the sign is applied once in FIX.
module mult_seq #(
  parameter int WIDTH      = 32,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic      clk,
  input  logic      rst,
  mult_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state, state_nxt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mag_b;
  logic [CW-1:0]      cnt;
  logic               neg;
  logic               done_q;
  logic [2*WIDTH-1:0] product_q;

  // Operand magnitudes; -(most negative) wraps to 2^(WIDTH-1), which is the
  // exact magnitude when read as unsigned.
  logic [WIDTH-1:0]   mag_a_in, mag_b_in;
  logic               neg_in;
  assign mag_a_in = (bus.is_signed && bus.multiplicand[WIDTH-1]) ? -bus.multiplicand
                                                                  : bus.multiplicand;
  assign mag_b_in = (bus.is_signed && bus.multiplier[WIDTH-1])   ? -bus.multiplier
                                                                  : bus.multiplier;
  assign neg_in   = bus.is_signed && (bus.multiplicand[WIDTH-1] ^ bus.multiplier[WIDTH-1]);

  // One iteration's worth of datapath, shared by the RUN state.
  logic [2*WIDTH-1:0] acc_sum;
  logic [WIDTH-1:0]   mag_b_shr;
  logic               last_iter;
  assign acc_sum   = mag_b[0] ? acc + mcand : acc;
  assign mag_b_shr = mag_b >> 1;
  assign last_iter = (cnt == CW'(1)) || (EARLY_EXIT && (mag_b_shr == '0));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last_iter) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: load on accept, shift-add in RUN, sign-correct and publish in FIX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      mcand     <= '0;
      mag_b     <= '0;
      cnt       <= '0;
      neg       <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          acc   <= '0;
          mcand <= {{WIDTH{1'b0}}, mag_a_in};
          mag_b <= mag_b_in;
          neg   <= neg_in;
          cnt   <= CW'(WIDTH);
        end
        RUN: begin
          acc   <= acc_sum;
          mcand <= mcand << 1;
          mag_b <= mag_b_shr;
          cnt   <= cnt - CW'(1);
        end
        FIX: begin
          // -0 is 0 in two's complement, so a zero result never reads negative.
          product_q <= neg ? -acc : acc;
          done_q    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = (state != IDLE);
  assign bus.done    = done_q;
  assign bus.product = product_q;
endmodule

// File: tb/tb_mult_seq.sv
// Bench for mult_seq: three instances (32-bit early-exit, 32-bit fixed
// iteration count, 8-bit early-exit) checked against arithmetic reference.
module tb_mult_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mult_seq_if #(.WIDTH(32)) if_a ();
  mult_seq_if #(.WIDTH(32)) if_b ();
  mult_seq_if #(.WIDTH(8))  if_c ();

  mult_seq #(.WIDTH(32), .EARLY_EXIT(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
  mult_seq #(.WIDTH(32), .EARLY_EXIT(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));
  mult_seq #(.WIDTH(8),  .EARLY_EXIT(1'b1)) dut_c (.clk(clk), .rst(rst), .bus(if_c.slave));

  // sel: 0 = 32-bit early exit, 1 = 32-bit full, 2 = 8-bit early exit
  function automatic int w_of(int sel);
    return (sel == 2) ? 8 : 32;
  endfunction
  function automatic bit ee_of(int sel);
    return (sel != 1);
  endfunction

  function automatic logic [127:0] ref_mul(logic [63:0] a, logic [63:0] b, bit s, int w);
    logic [127:0] mw, m2w, ea, eb;
    mw  = (128'd1 << w) - 1;
    m2w = (128'd1 << (2 * w)) - 1;
    ea  = {64'd0, a} & mw;
    eb  = {64'd0, b} & mw;
    if (s && ea[w-1]) ea = ea | ~mw;
    if (s && eb[w-1]) eb = eb | ~mw;
    return (ea * eb) & m2w;
  endfunction

  // Edges from accept to done visible: iteration count plus the FIX edge.
  function automatic int ref_lat(logic [63:0] b, bit s, int w, bit ee);
    logic [127:0] mw, mb;
    int bits;
    mw = (128'd1 << w) - 1;
    mb = {64'd0, b} & mw;
    if (s && mb[w-1]) mb = ((~mb) + 128'd1) & mw;
    bits = 0;
    while (mb != 0) begin bits++; mb = mb >> 1; end
    if (!ee) return w + 1;
    return ((bits == 0) ? 1 : bits) + 1;
  endfunction

  task automatic drive(int sel, bit st, logic [63:0] a, logic [63:0] b, bit s);
    case (sel)
      0: begin if_a.start = st; if_a.multiplicand = a[31:0]; if_a.multiplier = b[31:0]; if_a.is_signed = s; end
      1: begin if_b.start = st; if_b.multiplicand = a[31:0]; if_b.multiplier = b[31:0]; if_b.is_signed = s; end
      default: begin if_c.start = st; if_c.multiplicand = a[7:0]; if_c.multiplier = b[7:0]; if_c.is_signed = s; end
    endcase
  endtask

  function automatic bit get_done(int sel);
    return (sel == 0) ? if_a.done : (sel == 1) ? if_b.done : if_c.done;
  endfunction
  function automatic bit get_busy(int sel);
    return (sel == 0) ? if_a.busy : (sel == 1) ? if_b.busy : if_c.busy;
  endfunction
  function automatic logic [127:0] get_prod(int sel);
    return (sel == 0) ? {64'd0, if_a.product} : (sel == 1) ? {64'd0, if_b.product}
                      : {112'd0, if_c.product};
  endfunction

  // One operation; operands are scrambled after accept since they are don't-care.
  task automatic run_op(int sel, logic [63:0] a, logic [63:0] b, bit s,
                        output logic [127:0] p, output int lat, output bit busy0);
    @(negedge clk);
    drive(sel, 1'b1, a, b, s);
    @(posedge clk); #1;
    busy0 = get_busy(sel);
    drive(sel, 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
    lat = 0;
    while (!get_done(sel) && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    p = get_prod(sel);
  endtask

  // busy and done must never overlap on any instance.
  always @(negedge clk) begin
    if ((if_a.busy && if_a.done) || (if_b.busy && if_b.done) || (if_c.busy && if_c.done)) begin
      n_err++;
      $display("FAIL busy_done_overlap at %0t", $time);
    end
  end

  task automatic test_reset();
    for (int i = 0; i < 3; i++) drive(i, 1'b0, 64'd0, 64'd0, 1'b0);
    #1;
    n_cmp++; if (if_a.busy !== 1'b0)  begin n_err++; $display("FAIL reset_busy: got %b want 0", if_a.busy); end
    n_cmp++; if (if_a.done !== 1'b0)  begin n_err++; $display("FAIL reset_done: got %b want 0", if_a.done); end
    n_cmp++; if (if_a.product !== '0) begin n_err++; $display("FAIL reset_product: got %0h want 0", if_a.product); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
  endtask

  typedef struct {
    int           sel;
    logic [63:0]  a, b;
    bit           s;
    logic [127:0] p;
    int           lat;
  } vec_t;

  task automatic test_directed();
    vec_t v[8];
    logic [127:0] p;
    int lat;
    bit b0;
    v[0] = '{0, 64'hFFFF_FFFD, 64'd7,         1'b1, 128'hFFFF_FFFF_FFFF_FFEB, 4};
    v[1] = '{0, 64'h8000_0000, 64'h8000_0000, 1'b1, 128'h4000_0000_0000_0000, 33};
    v[2] = '{0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b0, 128'hFFFF_FFFE_0000_0001, 33};
    v[3] = '{1, 64'd12345,     64'd0,         1'b0, 128'd0, 33};
    v[4] = '{0, 64'd12345,     64'd0,         1'b0, 128'd0, 2};
    v[5] = '{2, 64'h80,        64'h7F,        1'b1, 128'hC080, 8};
    v[6] = '{2, 64'h80,        64'h7F,        1'b0, 128'h3F80, 8};
    v[7] = '{0, 64'hFFFF_FFFB, 64'd0,         1'b1, 128'd0, 2};
    for (int i = 0; i < 8; i++) begin
      run_op(v[i].sel, v[i].a, v[i].b, v[i].s, p, lat, b0);
      n_cmp++; if (b0 !== 1'b1) begin n_err++; $display("FAIL dir%0d_busy: got %b want 1", i, b0); end
      n_cmp++; if (p !== v[i].p) begin n_err++; $display("FAIL dir%0d_product: got %0h want %0h", i, p, v[i].p); end
      n_cmp++; if (lat != v[i].lat) begin n_err++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, v[i].lat); end
    end
  endtask

  task automatic test_random();
    logic [127:0] p, ep;
    logic [63:0] a, b;
    int lat, el, sel;
    bit s, b0;
    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 2);
      a   = {32'd0, $urandom};
      b   = {32'd0, $urandom >> $urandom_range(0, 31)};
      if ($urandom_range(0, 3) == 0) b = ~b;
      s   = 1'($urandom);
      run_op(sel, a, b, s, p, lat, b0);
      ep = ref_mul(a, b, s, w_of(sel));
      el = ref_lat(b, s, w_of(sel), ee_of(sel));
      n_cmp++; if (p !== ep) begin n_err++; $display("FAIL rand%0d_product: got %0h want %0h", i, p, ep); end
      n_cmp++; if (lat != el) begin n_err++; $display("FAIL rand%0d_latency: got %0d want %0d", i, lat, el); end
    end
  endtask

  task automatic test_busy_ignore();
    logic [127:0] ep;
    int lat;
    ep = ref_mul(64'h1234, 64'hFFFF, 1'b0, 32);
    @(negedge clk);
    drive(0, 1'b1, 64'h1234, 64'hFFFF, 1'b0);
    @(posedge clk); #1;
    lat = 0;
    while (!if_a.done && lat < 100) begin
      if (lat == 3) drive(0, 1'b1, 64'h55, 64'h77, 1'b1);
      else          drive(0, 1'b0, 64'h0, 64'h0, 1'b0);
      @(posedge clk); #1;
      lat++;
    end
    n_cmp++; if (if_a.product !== ep[63:0]) begin n_err++; $display("FAIL ignore_product: got %0h want %0h", if_a.product, ep[63:0]); end
    n_cmp++; if (lat != 17) begin n_err++; $display("FAIL ignore_latency: got %0d want 17", lat); end
    @(posedge clk); #1;
    n_cmp++; if (if_a.busy !== 1'b0) begin n_err++; $display("FAIL ignore_not_queued: got busy %b want 0", if_a.busy); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] e1, e2;
    int lat, el2;
    e1  = ref_mul(64'd6, 64'h100, 1'b0, 32);
    e2  = ref_mul(64'hFFFF_FFF9, 64'd9, 1'b1, 32);
    el2 = ref_lat(64'd9, 1'b1, 32, 1'b1);
    @(negedge clk);
    drive(0, 1'b1, 64'd6, 64'h100, 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b1, 64'hFFFF_FFF9, 64'd9, 1'b1);
    lat = 0;
    while (!if_a.done && lat < 100) begin @(posedge clk); #1; lat++; end
    n_cmp++; if (if_a.product !== e1[63:0]) begin n_err++; $display("FAIL b2b_first_product: got %0h want %0h", if_a.product, e1[63:0]); end
    n_cmp++; if (if_a.busy !== 1'b0) begin n_err++; $display("FAIL b2b_busy_gap: got %b want 0", if_a.busy); end
    @(posedge clk); #1;
    n_cmp++; if (if_a.busy !== 1'b1) begin n_err++; $display("FAIL b2b_restart: got busy %b want 1", if_a.busy); end
    drive(0, 1'b0, 64'd0, 64'd0, 1'b0);
    lat = 0;
    while (!if_a.done && lat < 100) begin @(posedge clk); #1; lat++; end
    n_cmp++; if (if_a.product !== e2[63:0]) begin n_err++; $display("FAIL b2b_second_product: got %0h want %0h", if_a.product, e2[63:0]); end
    n_cmp++; if (lat != el2) begin n_err++; $display("FAIL b2b_second_latency: got %0d want %0d", lat, el2); end
  endtask

  task automatic test_rst_mid();
    logic [127:0] p;
    int lat;
    bit b0;
    @(negedge clk);
    drive(0, 1'b1, 64'hDEAD_BEEF, 64'h8000_0001, 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b0, 64'd0, 64'd0, 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    #1;
    n_cmp++; if (if_a.busy !== 1'b0)  begin n_err++; $display("FAIL rstmid_busy: got %b want 0", if_a.busy); end
    n_cmp++; if (if_a.done !== 1'b0)  begin n_err++; $display("FAIL rstmid_done: got %b want 0", if_a.done); end
    n_cmp++; if (if_a.product !== '0) begin n_err++; $display("FAIL rstmid_product: got %0h want 0", if_a.product); end
    @(negedge clk) rst = 1'b0;
    run_op(0, 64'd6, 64'd7, 1'b0, p, lat, b0);
    n_cmp++; if (p !== 128'd42) begin n_err++; $display("FAIL rstmid_next_product: got %0d want 42", p); end
    n_cmp++; if (lat != 4) begin n_err++; $display("FAIL rstmid_next_latency: got %0d want 4", lat); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_busy_ignore();
    test_back_to_back();
    test_rst_mid();
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
